// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversampling
// factor, default word width and the bit-timer reload helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE         = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CNT_W              = 19;

    // Reload value for a full bit period, or half of one to land mid start bit.
    function automatic logic [CNT_W-1:0] cnt_load(input logic [15:0] p, input logic half_bit);
        logic [CNT_W-1:0] t;
        t = CNT_W'(p) * CNT_W'(OVERSAMPLE);
        if (half_bit) begin
            t = t >> 1;
        end
        return t - CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// RST_VAL sets what both flops hold while reset is asserted.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8x oversampled bit timer, LSB-first, one stop bit, AXI-Stream output.
// A word lands one clock after the stop-bit sample; unread words are overwritten (overrun).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic                  w_rxd;
    logic                  w_expire;
    logic                  w_handshake;
    uart_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_prescale;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_armed;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd)
    );

    assign w_expire    = (r_cnt == '0);
    assign w_handshake = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_prescale    <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_armed       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;

            if (w_handshake) begin
                m_axis_tvalid <= 1'b0;
            end

            if (r_state != IDLE && !w_expire) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    // A start needs a high-to-low transition seen after reset or a finished frame.
                    if (w_rxd) begin
                        r_armed <= 1'b1;
                    end else if (r_armed && prescale != 16'd0) begin
                        r_prescale <= prescale;
                        r_cnt      <= cnt_load(prescale, 1'b1);
                        r_armed    <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_expire) begin
                        if (!w_rxd) begin
                            r_cnt     <= cnt_load(r_prescale, 1'b0);
                            r_bit_cnt <= '0;
                            r_state   <= DATA;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_expire) begin
                        r_shift <= DATA_WIDTH'({w_rxd, r_shift} >> 1);
                        r_cnt   <= cnt_load(r_prescale, 1'b0);
                        if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_expire) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                        if (w_rxd) begin
                            // A word consumed in this same cycle makes room, so no overrun.
                            m_axis_tdata  <= r_shift;
                            m_axis_tvalid <= 1'b1;
                            overrun_error <= m_axis_tvalid && !m_axis_tready;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port rxd, input, 1: serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port prescale, input, 16: clock cycles per 1/8 bit, so bit period = prescale*8 clocks (54 at 50 MHz gives 115200 baud).
REQ-006 SHALL have port m_axis_tdata, output, DATA_WIDTH: received word.
REQ-007 SHALL have port m_axis_tvalid, output, 1: tdata holds an unconsumed word.
REQ-008 SHALL have port m_axis_tready, input, 1: downstream accepts the word.
REQ-009 SHALL have port busy, output, 1: a frame is in progress.
REQ-010 SHALL have port overrun_error, output, 1: one-cycle pulse when a word is lost.
REQ-011 SHALL have port frame_error, output, 1: one-cycle pulse when the stop bit is sampled low.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL implement states IDLE, START, DATA, STOP; busy = 1 in every state except IDLE.
REQ-014 IDLE: on synchronized rxd = 0 with prescale != 0, SHALL latch prescale, load the counter with prescale*4-1 and enter START; prescale = 0 keeps the block in IDLE.
REQ-015 START: at counter expiry, sampled 0 SHALL enter DATA with counter prescale*8-1; sampled 1 (glitch) SHALL return to IDLE with no output or error.
REQ-016 DATA: SHALL sample one bit per counter expiry, LSB first, shifting into a DATA_WIDTH register; after DATA_WIDTH bits SHALL enter STOP.
REQ-017 STOP: at counter expiry, sampled 1 SHALL load m_axis_tdata and set m_axis_tvalid on the next edge; sampled 0 SHALL pulse frame_error, leave tdata/tvalid unchanged and not load the word.
REQ-018 After STOP SHALL return to IDLE and require rxd = 1 for at least one synchronized cycle before a new start is detected.
REQ-019 Counter width SHALL be 19 bits; prescale changes mid-frame SHALL be ignored until the next start.
REQ-020 m_axis_tvalid SHALL stay high with tdata stable until the cycle where tvalid && tready, then clear.
REQ-021 A new word arriving while tvalid = 1 and tready = 0 SHALL overwrite tdata, keep tvalid = 1 and pulse overrun_error.
REQ-022 A new word arriving in the same cycle as a tvalid && tready handshake SHALL keep tvalid = 1 with the new data and SHALL NOT flag overrun.
REQ-023 Latency: tvalid SHALL rise one clock after the stop-bit sample point, which is 9.5 bit periods after start-edge detection.

Reset
REQ-024 On rst, SHALL immediately set state IDLE, counter 0, m_axis_tdata 0, m_axis_tvalid 0, busy 0, overrun_error 0, frame_error 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL discard the partial word; after release the first falling edge SHALL start a fresh frame.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, the OVERSAMPLE = 8 constant and the default DATA_WIDTH, shared with uart_tx.
REQ-027 Sub-module uart_rx_sync (2-flop synchronizer with reset value parameter) SHALL be instantiated once for rxd.

Verification (50 MHz clk, prescale = 54, bit = 432 clocks, drive rxd from uart_tx)
REQ-028 Byte 0x69, tready = 1 -> tvalid one cycle, tdata = 0x69, about 4104 clocks after the start edge, no error flags.
REQ-029 Back-to-back 0x69 then 0x94, tready = 1 -> two handshakes with 0x69 then 0x94; busy drops only between frames.
REQ-030 rxd low for 100 clocks then high -> no tvalid, no error flags, busy returns to 0 at the half-bit point.
REQ-031 Frame 0x55 with stop bit forced 0 -> frame_error pulses once, tvalid stays 0.
REQ-032 Bytes 0xA5 then 0x3C with tready = 0 -> overrun_error pulses once at the second stop, tdata = 0x3C, tvalid = 1.
REQ-033 rst asserted mid-DATA, released, then byte 0x81 sent -> only 0x81 is delivered.
